// File: rtl/add32_share_arbiter.sv
// add32_share_arbiter: round-robin sharing of one fabric adder among NUM_REQ requesters; optional sum check via ADD_SHARE_CHECK_EN
module add32_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 32,
  parameter int SETTLE = 2,
  parameter int IDW = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [IDW-1:0]           resp_id,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     busy,
  output logic                     chk_err
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [IDW-1:0] last_q, id_q, grant, idx;
  logic [3:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic found, accept, capture;
  // first valid requester searching upward from the previous winner, wrapping
  always_comb begin
    grant = last_q;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  assign accept = rst_n && (state_q == IDLE) && found;
  assign capture = (state_q == WAIT) && (cnt_q == 4'd1);
  // next state: grant, settle, then hold the response until taken
  always_comb begin
    state_d = state_q;
    if (accept) state_d = WAIT;
    else if (capture) state_d = RESP;
    else if (state_q == RESP && resp_ready) state_d = IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end
  // operand latch, settle counter and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IDW'(NUM_REQ - 1);
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      sum_q <= '0;
      id_q <= '0;
    end else begin
      if (accept) begin
        a_q <= req_a[int'(grant)*WIDTH +: WIDTH];
        b_q <= req_b[int'(grant)*WIDTH +: WIDTH];
        last_q <= grant;
        cnt_q <= 4'(SETTLE);
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) begin
        sum_q <= add_sum;
        id_q <= last_q;
      end
    end
  end
`ifdef ADD_SHARE_CHECK_EN
  logic chk_q;
  // sticky flag when the fabric sum disagrees with a local adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chk_q <= 1'b0;
    else if (capture && add_sum != a_q + b_q) chk_q <= 1'b1;
  end
  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif
  assign req_ready = accept ? NUM_REQ'(1) << grant : '0;
  assign add_a = a_q;
  assign add_b = b_q;
  assign resp_valid = state_q == RESP;
  assign resp_id = id_q;
  assign resp_sum = sum_q;
  assign busy = state_q != IDLE;
endmodule
